// File: rtl/bht_predictor_if.sv
// ---------------------------------------------------------------------------
// bht_predictor_if
//   Lookup and training bundle between the fetch/execute stages and the
//   branch history table.
//   master : fetch/execute side (drives lookup and training requests)
//   slave  : predictor side (returns prediction, history snapshot, stats)
//   Signals:
//     en, read_addr             lookup request and PC index bits
//     prediction, pred_valid    registered prediction, valid one cycle later
//     pred_hist                 GHR snapshot used for the lookup
//     update_*                  resolved-branch training event
//     mispredict_cnt            saturating mispredict statistic
// ---------------------------------------------------------------------------
interface bht_predictor_if #(
    parameter int INDEX_BITS = 5,
    parameter int HIST_BITS  = 5
);
    logic                  en;
    logic [INDEX_BITS-1:0] read_addr;
    logic                  prediction;
    logic                  pred_valid;
    logic [HIST_BITS-1:0]  pred_hist;
    logic                  update_en;
    logic [INDEX_BITS-1:0] update_addr;
    logic [HIST_BITS-1:0]  update_hist;
    logic                  update_taken;
    logic                  update_mispredict;
    logic [15:0]           mispredict_cnt;

    modport master (
        output en, read_addr,
        output update_en, update_addr, update_hist, update_taken, update_mispredict,
        input  prediction, pred_valid, pred_hist, mispredict_cnt
    );

    modport slave (
        input  en, read_addr,
        input  update_en, update_addr, update_hist, update_taken, update_mispredict,
        output prediction, pred_valid, pred_hist, mispredict_cnt
    );
endinterface

// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor
//   Table of 2^INDEX_BITS saturating counters, indexed by PC bits (bimodal)
//   or PC bits XOR global history (gshare). Registered prediction one cycle
//   after a lookup; trained from execute, with GHR repair on mispredict.
//   Ports:
//     clk   rising-edge clock
//     arst  asynchronous reset, active-high
//     bus   bht_predictor_if.slave (lookup, training, statistics)
// ---------------------------------------------------------------------------
module bht_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int CNT_BITS   = 2,
    parameter int HIST_BITS  = 5,
    parameter int GSHARE     = 0,
    parameter int INIT_STATE = 1
) (
    input  logic            clk,
    input  logic            arst,
    bht_predictor_if.slave  bus
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [CNT_BITS-1:0]   table_q [DEPTH];
    logic [HIST_BITS-1:0]  ghr_q;
    logic                  prediction_q;
    logic                  pred_valid_q;
    logic [HIST_BITS-1:0]  pred_hist_q;
    logic [15:0]           mispredict_cnt_q;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [CNT_BITS-1:0]   up_cnt_next;
    logic [CNT_BITS-1:0]   rd_cnt;
    logic                  pred_bit;
    logic                  restore;

    // NOTE: every always_comb output is given a default first so no path
    // leaves a signal unassigned (which would infer a latch).
    always_comb begin
        rd_idx      = bus.read_addr;
        up_idx      = bus.update_addr;
        if (GSHARE != 0) begin
            rd_idx = bus.read_addr ^ INDEX_BITS'(ghr_q);
            up_idx = bus.update_addr ^ INDEX_BITS'(bus.update_hist);
        end

        // Saturating step of the entry being trained.
        up_cnt_next = table_q[up_idx];
        if (bus.update_taken) begin
            if (up_cnt_next != {CNT_BITS{1'b1}})
                up_cnt_next = up_cnt_next + 1'b1;
        end else begin
            if (up_cnt_next != '0)
                up_cnt_next = up_cnt_next - 1'b1;
        end

        // Write-first: a same-cycle update of the looked-up entry is seen.
        rd_cnt = table_q[rd_idx];
        if (bus.update_en && (up_idx == rd_idx))
            rd_cnt = up_cnt_next;

        pred_bit = rd_cnt[CNT_BITS-1];
        restore  = bus.update_en && bus.update_mispredict;
    end

    // NOTE: the counter table is reset on purpose -- the predictor must come
    // out of reset with every entry at INIT_STATE, so this is flops, not RAM.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++)
                table_q[i] <= CNT_BITS'(INIT_STATE);
        end else if (bus.update_en) begin
            table_q[up_idx] <= up_cnt_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ghr_q            <= '0;
            prediction_q     <= 1'b0;
            pred_valid_q     <= 1'b0;
            pred_hist_q      <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            // Restore beats the speculative shift; the lookup itself still
            // used the pre-restore history.
            if (restore)
                ghr_q <= HIST_BITS'({bus.update_hist, bus.update_taken});
            else if (bus.en)
                ghr_q <= HIST_BITS'({ghr_q, pred_bit});

            pred_valid_q <= bus.en;
            if (bus.en) begin
                prediction_q <= pred_bit;
                pred_hist_q  <= ghr_q;
            end

            if (restore && (mispredict_cnt_q != 16'hFFFF))
                mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
    end

    assign bus.prediction     = prediction_q;
    assign bus.pred_valid     = pred_valid_q;
    assign bus.pred_hist      = pred_hist_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule
